// File: rtl/instr_decode.sv
// Single-stage instruction decoder feeding a register-file stage over a valid/ready handshake.
// Optional load-use interlock is enabled by defining LOAD_USE_INTERLOCK_EN.
module instr_decode #(
  localparam int unsigned INSTR_W = 9,
  localparam int unsigned REG_W   = 2,
  localparam int unsigned ALU_W   = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               InValid,
  output logic               InReady,
  input  logic               OutReady,
  output logic               OutValid,
  output logic [REG_W-1:0]   RaddrA,
  output logic [REG_W-1:0]   RaddrB,
  output logic [REG_W-1:0]   Waddr,
  output logic               WriteEn,
  output logic               MovEn,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [ALU_W-1:0]   AluOp,
  output logic               Halted
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0] waddr;
    logic [REG_W-1:0] raddr_a;
    logic [REG_W-1:0] raddr_b;
    logic             write_en;
    logic             mov_en;
    logic             mem_read;
    logic             mem_write;
    logic [ALU_W-1:0] alu_op;
  } ctrl_t;

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] fa;
  logic [REG_W-1:0] fb;
  logic [REG_W-1:0] fc;
  ctrl_t            dec;
  ctrl_t            ctrl_q;
  logic             out_valid_q;
  logic             halted_q;
  state_t           state_q;
  logic             hazard;
  logic             transfer;
  logic             is_halt;

  assign op = Instr[8:6];
  assign fa = Instr[5:4];
  assign fb = Instr[3:2];
  assign fc = Instr[1:0];
  assign is_halt = (op == 3'b111);

  // Decode table; every field defaults to zero.
  always_comb begin
    dec = '0;
    if (!op[2]) begin
      dec.waddr    = fa;
      dec.raddr_a  = fa;
      dec.raddr_b  = fb;
      dec.alu_op   = op[1:0];
      dec.write_en = 1'b1;
    end else begin
      case (op[1:0])
        2'b00: begin
          dec.waddr   = fa;
          dec.raddr_a = fb;
          dec.raddr_b = fc;
          dec.mov_en  = 1'b1;
        end
        2'b01: begin
          dec.waddr    = fa;
          dec.raddr_a  = fb;
          dec.write_en = 1'b1;
          dec.mem_read = 1'b1;
        end
        2'b10: begin
          dec.raddr_a   = fa;
          dec.raddr_b   = fb;
          dec.mem_write = 1'b1;
        end
        default: dec = '0;
      endcase
    end
  end

`ifdef LOAD_USE_INTERLOCK_EN
  logic use_fa;
  logic use_fb;

  // fa is a source for ALU and ST; fb for ALU, LD and ST.
  assign use_fa = !op[2] || (op == 3'b110);
  assign use_fb = !op[2] || (op == 3'b101) || (op == 3'b110);
  assign hazard = out_valid_q && ctrl_q.mem_read && OutReady && InValid &&
                  ((use_fa && (fa == ctrl_q.waddr)) || (use_fb && (fb == ctrl_q.waddr)));
`else
  assign hazard = 1'b0;
`endif

  assign InReady  = (state_q != ST_HALTED) && (!out_valid_q || OutReady) && !hazard;
  assign transfer = InValid && InReady;

  // Output pipeline register and control state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      if (transfer) begin
        ctrl_q      <= dec;
        out_valid_q <= 1'b1;
      end else if (OutReady) begin
        // Drained or bubbled: clear the bundle so enables read as zero when invalid.
        ctrl_q      <= '0;
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_RUN: begin
          if (hazard)                    state_q <= ST_BUBBLE;
          else if (transfer && is_halt)  state_q <= ST_HALTED;
        end
        ST_BUBBLE: begin
          if (transfer && is_halt)       state_q <= ST_HALTED;
          else                           state_q <= ST_RUN;
        end
        ST_HALTED:                       state_q <= ST_HALTED;
        default:                         state_q <= ST_RUN;
      endcase

      if (transfer && is_halt) halted_q <= 1'b1;
    end
  end

  assign OutValid = out_valid_q;
  assign Waddr    = ctrl_q.waddr;
  assign RaddrA   = ctrl_q.raddr_a;
  assign RaddrB   = ctrl_q.raddr_b;
  assign WriteEn  = ctrl_q.write_en;
  assign MovEn    = ctrl_q.mov_en;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign AluOp    = ctrl_q.alu_op;
  assign Halted   = halted_q;

endmodule

// File: tb/tb_instr_decode.sv
// Directed testbench for instr_decode; expectations follow LOAD_USE_INTERLOCK_EN if defined.
module tb_instr_decode;

  logic       Clk;
  logic       Reset;
  logic [8:0] Instr;
  logic       InValid;
  logic       InReady;
  logic       OutReady;
  logic       OutValid;
  logic [1:0] RaddrA;
  logic [1:0] RaddrB;
  logic [1:0] Waddr;
  logic       WriteEn;
  logic       MovEn;
  logic       MemRead;
  logic       MemWrite;
  logic [1:0] AluOp;
  logic       Halted;

  int checks = 0;
  int errors = 0;

  // Bundle layout: {OutValid, Waddr, RaddrA, RaddrB, WriteEn, MovEn, MemRead, MemWrite, AluOp}
  localparam logic [12:0] E_NONE   = 13'd0;
  localparam logic [12:0] E_ADD12  = {1'b1, 2'd1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [12:0] E_SUB30  = {1'b1, 2'd3, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
  localparam logic [12:0] E_AND01  = {1'b1, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
  localparam logic [12:0] E_XOR22  = {1'b1, 2'd2, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
  localparam logic [12:0] E_MOV321 = {1'b1, 2'd3, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
  localparam logic [12:0] E_LD13   = {1'b1, 2'd1, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
  localparam logic [12:0] E_ST02   = {1'b1, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
  localparam logic [12:0] E_LD20   = {1'b1, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
  localparam logic [12:0] E_SUB23  = {1'b1, 2'd2, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
  localparam logic [12:0] E_ADD13  = {1'b1, 2'd1, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [12:0] E_HALT   = {1'b1, 12'd0};

  localparam logic [8:0] I_ADD12  = 9'b000_01_10_00;
  localparam logic [8:0] I_SUB30  = 9'b001_11_00_10;
  localparam logic [8:0] I_AND01  = 9'b010_00_01_00;
  localparam logic [8:0] I_XOR22  = 9'b011_10_10_11;
  localparam logic [8:0] I_MOV321 = 9'b100_11_10_01;
  localparam logic [8:0] I_LD13   = 9'b101_01_11_10;
  localparam logic [8:0] I_ST02   = 9'b110_00_10_11;
  localparam logic [8:0] I_LD20   = 9'b101_10_00_00;
  localparam logic [8:0] I_SUB23  = 9'b001_10_11_00;
  localparam logic [8:0] I_ADD13  = 9'b000_01_11_00;
  localparam logic [8:0] I_HALT   = 9'b111_00_00_00;

`ifdef LOAD_USE_INTERLOCK_EN
  localparam bit INTERLOCK = 1'b1;
`else
  localparam bit INTERLOCK = 1'b0;
`endif

  instr_decode dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Instr    (Instr),
    .InValid  (InValid),
    .InReady  (InReady),
    .OutReady (OutReady),
    .OutValid (OutValid),
    .RaddrA   (RaddrA),
    .RaddrB   (RaddrB),
    .Waddr    (Waddr),
    .WriteEn  (WriteEn),
    .MovEn    (MovEn),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .AluOp    (AluOp),
    .Halted   (Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [12:0] obs();
    return {OutValid, Waddr, RaddrA, RaddrB, WriteEn, MovEn, MemRead, MemWrite, AluOp};
  endfunction

  // Inputs change on negedge; registered outputs are read at the negedge, InReady 1 ns later.
  task automatic test_reset();
    @(negedge Clk);
    #1;
    checks++;
    if (obs() !== E_NONE) begin
      errors++; $display("FAIL reset_bundle got %b expected %b", obs(), E_NONE);
    end
    checks++;
    if (Halted !== 1'b0 || InReady !== 1'b1) begin
      errors++; $display("FAIL reset_flags got Halted=%b InReady=%b expected Halted=0 InReady=1", Halted, InReady);
    end
    @(negedge Clk);
    Reset = 1'b1; Instr = I_ADD12; InValid = 1'b1; OutReady = 1'b1;
    @(negedge Clk);
    checks++;
    if (obs() !== E_ADD12) begin
      errors++; $display("FAIL first_after_reset got %b expected %b", obs(), E_ADD12);
    end
    InValid = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_alu_back_to_back();
    logic [8:0]  vi [4] = '{I_ADD12, I_SUB30, I_AND01, I_XOR22};
    logic [12:0] ve [4] = '{E_ADD12, E_SUB30, E_AND01, E_XOR22};
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Instr = vi[i]; InValid = 1'b1;
      #1;
      checks++;
      if (InReady !== 1'b1) begin
        errors++; $display("FAIL alu_inready[%0d] got %b expected 1", i, InReady);
      end
      @(negedge Clk);
      checks++;
      if (obs() !== ve[i]) begin
        errors++; $display("FAIL alu_bundle[%0d] got %b expected %b", i, obs(), ve[i]);
      end
    end
    InValid = 1'b0;
    @(negedge Clk);
    checks++;
    if (obs() !== E_NONE) begin
      errors++; $display("FAIL alu_drain got %b expected %b", obs(), E_NONE);
    end
  endtask

  task automatic test_mov_mem();
    logic [8:0]  vi [3] = '{I_MOV321, I_LD13, I_ST02};
    logic [12:0] ve [3] = '{E_MOV321, E_LD13, E_ST02};
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Instr = vi[i]; InValid = 1'b1;
      @(negedge Clk);
      checks++;
      if (obs() !== ve[i]) begin
        errors++; $display("FAIL movmem_bundle[%0d] got %b expected %b", i, obs(), ve[i]);
      end
    end
    InValid = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_load_use();
    OutReady = 1'b1;
    Instr = I_LD20; InValid = 1'b1;
    @(negedge Clk);
    checks++;
    if (obs() !== E_LD20) begin
      errors++; $display("FAIL lu_load got %b expected %b", obs(), E_LD20);
    end
    Instr = I_SUB23;
    #1;
    checks++;
    if (InReady !== !INTERLOCK) begin
      errors++; $display("FAIL lu_inready got %b expected %b", InReady, !INTERLOCK);
    end
    @(negedge Clk);
    if (INTERLOCK) begin
      checks++;
      if (obs() !== E_NONE) begin
        errors++; $display("FAIL lu_bubble got %b expected %b", obs(), E_NONE);
      end
      #1;
      checks++;
      if (InReady !== 1'b1) begin
        errors++; $display("FAIL lu_bubble_inready got %b expected 1", InReady);
      end
      @(negedge Clk);
    end
    checks++;
    if (obs() !== E_SUB23) begin
      errors++; $display("FAIL lu_dependent got %b expected %b", obs(), E_SUB23);
    end
    // Independent consumer after a load never bubbles.
    Instr = I_LD20;
    @(negedge Clk);
    Instr = I_ADD13;
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++; $display("FAIL lu_indep_inready got %b expected 1", InReady);
    end
    @(negedge Clk);
    checks++;
    if (obs() !== E_ADD13) begin
      errors++; $display("FAIL lu_indep got %b expected %b", obs(), E_ADD13);
    end
    InValid = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_stall();
    OutReady = 1'b1;
    Instr = I_ADD12; InValid = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0; Instr = I_MOV321;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (InReady !== 1'b0) begin
        errors++; $display("FAIL stall_inready[%0d] got %b expected 0", i, InReady);
      end
      @(negedge Clk);
      checks++;
      if (obs() !== E_ADD12) begin
        errors++; $display("FAIL stall_hold[%0d] got %b expected %b", i, obs(), E_ADD12);
      end
    end
    OutReady = 1'b1;
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++; $display("FAIL stall_release_inready got %b expected 1", InReady);
    end
    @(negedge Clk);
    checks++;
    if (obs() !== E_MOV321) begin
      errors++; $display("FAIL stall_release got %b expected %b", obs(), E_MOV321);
    end
    InValid = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_halt();
    OutReady = 1'b1;
    Instr = I_HALT; InValid = 1'b1;
    @(negedge Clk);
    checks++;
    if (obs() !== E_HALT || Halted !== 1'b1) begin
      errors++; $display("FAIL halt_beat got %b Halted=%b expected %b Halted=1", obs(), Halted, E_HALT);
    end
    Instr = I_ADD12; OutReady = 1'b0;
    #1;
    checks++;
    if (InReady !== 1'b0) begin
      errors++; $display("FAIL halt_inready got %b expected 0", InReady);
    end
    @(negedge Clk);
    checks++;
    if (obs() !== E_HALT) begin
      errors++; $display("FAIL halt_hold got %b expected %b", obs(), E_HALT);
    end
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (InReady !== 1'b0) begin
        errors++; $display("FAIL halted_inready[%0d] got %b expected 0", i, InReady);
      end
      @(negedge Clk);
      checks++;
      if (obs() !== E_NONE || Halted !== 1'b1) begin
        errors++; $display("FAIL halted_out[%0d] got %b Halted=%b expected %b Halted=1", i, obs(), Halted, E_NONE);
      end
    end
    // Asynchronous reset out of HALTED, mid-cycle.
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (obs() !== E_NONE || Halted !== 1'b0 || InReady !== 1'b1) begin
      errors++; $display("FAIL halt_reset got %b Halted=%b InReady=%b expected %b Halted=0 InReady=1",
                         obs(), Halted, InReady, E_NONE);
    end
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (obs() !== E_ADD12) begin
      errors++; $display("FAIL halt_reset_accept got %b expected %b", obs(), E_ADD12);
    end
    InValid = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_stall();
    OutReady = 1'b0;
    Instr = I_ADD12; InValid = 1'b1;
    @(negedge Clk);
    checks++;
    if (obs() !== E_ADD12) begin
      errors++; $display("FAIL mid_stall_load got %b expected %b", obs(), E_ADD12);
    end
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (obs() !== E_NONE || InReady !== 1'b1) begin
      errors++; $display("FAIL mid_stall_reset got %b InReady=%b expected %b InReady=1", obs(), InReady, E_NONE);
    end
    @(negedge Clk);
    Reset = 1'b1; Instr = I_MOV321; OutReady = 1'b1;
    @(negedge Clk);
    checks++;
    if (obs() !== E_MOV321) begin
      errors++; $display("FAIL mid_stall_accept got %b expected %b", obs(), E_MOV321);
    end
    InValid = 1'b0;
    @(negedge Clk);
    checks++;
    if (obs() !== E_NONE) begin
      errors++; $display("FAIL mid_stall_drain got %b expected %b", obs(), E_NONE);
    end
  endtask

  initial begin
    Reset = 1'b0; Instr = '0; InValid = 1'b0; OutReady = 1'b0;
    repeat (2) @(negedge Clk);
    test_reset();
    test_alu_back_to_back();
    test_mov_mem();
    test_load_use();
    test_stall();
    test_halt();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-002 Reset  input  1  asynchronous, active-low reset; Reset=0 clears all state immediately, independent of Clk.
REQ-003 Instr  input  9  instruction word: op=Instr[8:6], fa=Instr[5:4], fb=Instr[3:2], fc=Instr[1:0].
REQ-004 InValid  input  1  Instr is valid this cycle.
REQ-005 InReady  output  1  block accepts Instr this cycle; transfer = InValid && InReady.
REQ-006 OutReady  input  1  register file stage consumes outputs this cycle.
REQ-007 OutValid  output  1  registered control bundle below is valid.
REQ-008 RaddrA, RaddrB, Waddr  output  2 each  register file read/write pointers.
REQ-009 WriteEn, MovEn, MemRead, MemWrite  output  1 each  register file and memory enables.
REQ-010 AluOp  output  2  ALU function: 00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-011 Halted  output  1  HALT has been accepted.

Function
REQ-012 Decode table, applied at transfer:
- op 0xx (ALU): Waddr=RaddrA=fa, RaddrB=fb, AluOp=op[1:0], WriteEn=1.
- op 100 (MOV): Waddr=fa, RaddrA=fb, RaddrB=fc, MovEn=1, WriteEn=0.
- op 101 (LD): Waddr=fa, RaddrA=fb, RaddrB=0, WriteEn=1, MemRead=1.
- op 110 (ST): RaddrA=fa, RaddrB=fb, Waddr=0, MemWrite=1.
- op 111 (HALT): all enables 0, pointers 0.
- Every enable not listed is 0; AluOp=00 for non-ALU ops.
REQ-013 Source registers for hazard checks: ALU {fa,fb}; LD {fb}; ST {fa,fb}; MOV and HALT none.
REQ-014 Output bundle is a single pipeline register; latency from Instr transfer to OutValid is exactly 1 cycle.
REQ-015 Bundle and OutValid hold stable while OutValid=1 and OutReady=0.
REQ-016 InReady = (state != HALTED) && (!OutValid || OutReady) && !hazard, combinational.
REQ-017 On a transfer the register loads the decoded bundle with OutValid=1; otherwise, if OutReady=1, OutValid clears to 0.
REQ-018 State machine RUN, BUBBLE, HALTED:
- RUN->BUBBLE on hazard.
- BUBBLE->RUN after exactly 1 cycle.
- RUN->HALTED on a HALT transfer.
- HALTED is left only by Reset.
REQ-019 hazard = OutValid && MemRead && OutReady && InValid && (Waddr of the held LD equals any source register of Instr).
REQ-020 On hazard: no transfer; the output register loads a bubble (OutValid=0, all enables 0); the same Instr is accepted the next cycle.
REQ-021 In BUBBLE with OutValid=0, no hazard can be raised.
REQ-022 HALT produces one OutValid beat; Halted=1 from the cycle after the HALT transfer; InReady=0 while HALTED; a held bundle still drains on OutReady.
REQ-023 Back-to-back transfers with OutReady=1 sustain one instruction per cycle absent hazards.

Reset
REQ-024 While Reset=0: state=RUN, OutValid=0, Halted=0, every pointer, enable and AluOp=0.
REQ-025 Reset is asserted asynchronously and released synchronously to Clk; first transfer is possible on the first posedge after release.
REQ-026 Reset mid-stall, mid-bubble or in HALTED discards the held bundle with no OutValid beat.

Configuration
REQ-027 Macro LOAD_USE_INTERLOCK_EN.
- Defined: REQ-019 to REQ-021 apply.
- Undefined: hazard is constant 0, BUBBLE is unreachable, and load-use ordering is the compiler's responsibility.

Verification
REQ-028 Reset=0 mid-stream, then released -> all outputs 0 and InReady=1 within the same cycle; first Instr accepted on the next posedge.
REQ-029 ADD r1,r2 (0_00_01_10_00), OutReady=1 -> next cycle OutValid=1, Waddr=1, RaddrA=1, RaddrB=2, WriteEn=1, AluOp=00.
REQ-030 MOV r3,{2,1} (1_00_11_10_01) -> Waddr=3, RaddrA=2, RaddrB=1, MovEn=1, WriteEn=0.
REQ-031 LD r2,[r0] then SUB r2,r3, with the macro defined -> one OutValid=0 bubble between the two beats and InReady=0 for 1 cycle; with the macro undefined -> no bubble.
REQ-032 OutReady held 0 for 3 cycles with OutValid=1 -> bundle unchanged and InReady=0 throughout; OutReady=1 -> the next Instr is accepted that cycle.
REQ-033 HALT then ADD presented -> HALT beat output, Halted=1, ADD never accepted until Reset.
